// File: rtl/fp_mul_seq_if.sv
// fp_mul_seq_if: operand/result bundle for the multicycle FP multiplier.
// Carries the input handshake (in_valid/in_ready, a, b), the output
// handshake (out_valid/out_ready, p and the per-operation flags) and the
// sticky-status controls (clr_sticky, sticky_flags).
//   master: the issuing side (drives operands, out_ready, clr_sticky)
//   slave : the multiplier (drives in_ready, result, flags, sticky_flags)
interface fp_mul_seq_if #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
);
  localparam int W = 1 + EXP_W + MAN_W;

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] p;
  logic         of;
  logic         uf;
  logic         nan;
  logic         inf;
  logic         zf;
  logic         dnf;
  logic         nx;
  logic         clr_sticky;
  logic [6:0]   sticky_flags;

  modport master (
    output in_valid, a, b, out_ready, clr_sticky,
    input  in_ready, out_valid, p, of, uf, nan, inf, zf, dnf, nx, sticky_flags
  );

  modport slave (
    input  in_valid, a, b, out_ready, clr_sticky,
    output in_ready, out_valid, p, of, uf, nan, inf, zf, dnf, nx, sticky_flags
  );
endinterface

// File: rtl/fp_mul_seq.sv
// fp_mul_seq: multicycle IEEE-754 multiplier, generic in exponent/fraction
// width, round-to-nearest-even, flush-to-zero for denormal inputs and
// for underflowing results.
// Ports:
//   Clk  - clock, rising edge
//   Rst  - asynchronous active-high reset
//   bus  - fp_mul_seq_if.slave: operands a/b with in_valid/in_ready,
//          product p with flags {of,uf,nan,inf,zf,dnf,nx} and
//          out_valid/out_ready, clr_sticky and sticky_flags.
// Optional build macro FP_MUL_STICKY_EN: when defined, sticky_flags
// accumulates every completed flag vector and clr_sticky clears it;
// otherwise sticky_flags is constant 0.
module fp_mul_seq #(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int MUL_LAT = 2
) (
  input logic        Clk,
  input logic        Rst,
  fp_mul_seq_if.slave bus
);
  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int PW   = 2 * MAN_W + 2;
  localparam int EW   = EXP_W + 2;
  localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
  localparam int CW   = $clog2(MUL_LAT + 1);
  localparam logic signed [EW-1:0] EXP_MAX  = EW'((2 ** EXP_W) - 1);
  localparam logic signed [EW-1:0] EXP_ZERO = '0;

  typedef enum logic [2:0] {
    S_IDLE, S_UNPACK, S_MUL, S_NORM, S_ROUND, S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [W-1:0]          a_reg, b_reg, p_reg;
  logic                  sign_reg;
  logic signed [EW-1:0]  exp_reg;
  logic [CW-1:0]         cnt_reg;
  logic [MAN_W:0]        sig_reg;
  logic                  g_reg, r_reg, s_reg;
  logic [6:0]            flags_reg;
  logic [PW-1:0]         prod_pipe [MUL_LAT];

  // ---------------- operand classification (valid in UNPACK) ----------------
  logic             sa, sb;
  logic [EXP_W-1:0] ea, eb;
  logic [MAN_W-1:0] fa, fb;
  logic             a_inf, b_inf, a_zero, b_zero, a_dn, b_dn, any_nan, any_inf, special;
  logic signed [EW-1:0] exp_sum;
  logic [W-1:0]     spec_p;
  logic [6:0]       spec_flags;

  assign {sa, ea, fa} = a_reg;
  assign {sb, eb, fb} = b_reg;

  always_comb begin
    // Denormals collapse into signed zero, so exp==0 alone means zero here.
    a_zero  = ~|ea;
    b_zero  = ~|eb;
    a_dn    = a_zero & (|fa);
    b_dn    = b_zero & (|fb);
    a_inf   = (&ea) & ~|fa;
    b_inf   = (&eb) & ~|fb;
    any_nan = ((&ea) & (|fa)) | ((&eb) & (|fb)) | (a_inf & b_zero) | (b_inf & a_zero);
    any_inf = ~any_nan & (a_inf | b_inf);
    special = any_nan | a_inf | b_inf | a_zero | b_zero;
    exp_sum = EW'(ea) + EW'(eb) - EW'(BIAS);
    if (any_nan)
      spec_p = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    else if (any_inf)
      spec_p = {sa ^ sb, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    else
      spec_p = {sa ^ sb, {(EXP_W+MAN_W){1'b0}}};
    spec_flags = {2'b00, any_nan, any_inf, ~any_nan & ~any_inf, a_dn | b_dn, 1'b0};
  end

  // ---------------- significand multiplier pipeline ----------------
  // Free-running: operands are frozen from accept onward, so the last
  // stage holds the settled product once MUL has lasted MUL_LAT cycles.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) prod_pipe[0] <= '0;
    else     prod_pipe[0] <= PW'({1'b1, fa}) * PW'({1'b1, fb});
  end

  generate
    for (genvar gi = 1; gi < MUL_LAT; gi++) begin : g_mul_stage
      always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) prod_pipe[gi] <= '0;
        else     prod_pipe[gi] <= prod_pipe[gi-1];
      end
    end
  endgenerate

  // ---------------- normalise (used in NORM) ----------------
  // Product is in [1,4); shifting left when below 2 puts the leading one
  // at the top in both cases so the G/R/S positions are fixed.
  logic [PW-1:0] prod_n;
  assign prod_n = prod_pipe[MUL_LAT-1][PW-1] ? prod_pipe[MUL_LAT-1]
                                             : (prod_pipe[MUL_LAT-1] << 1);

  // ---------------- round and range check (used in ROUND) ----------------
  logic                 inc;
  logic [MAN_W+1:0]     rounded;
  logic                 carry;
  logic signed [EW-1:0] exp_fin;
  logic [MAN_W-1:0]     frac_fin;
  logic [W-1:0]         round_p;
  logic [6:0]           round_flags;

  always_comb begin
    inc      = g_reg & (r_reg | s_reg | sig_reg[0]);
    rounded  = {1'b0, sig_reg} + (MAN_W+2)'(inc);
    carry    = rounded[MAN_W+1];
    exp_fin  = exp_reg + EW'(carry);
    frac_fin = carry ? rounded[MAN_W:1] : rounded[MAN_W-1:0];
    if (exp_fin >= EXP_MAX) begin
      round_p     = {sign_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      round_flags = 7'b1001001;
    end else if (exp_fin <= EXP_ZERO) begin
      round_p     = {sign_reg, {(EXP_W+MAN_W){1'b0}}};
      round_flags = 7'b0100101;
    end else begin
      round_p     = {sign_reg, exp_fin[EXP_W-1:0], frac_fin};
      round_flags = {6'b000000, g_reg | r_reg | s_reg};
    end
  end

  // Result loaded on the cycle DONE is entered, from whichever path gets there.
  logic         done_entry;
  logic [W-1:0] res_p;
  logic [6:0]   res_flags;
  assign done_entry = (state_next == S_DONE) && (state_reg != S_DONE);
  assign res_p      = (state_reg == S_UNPACK) ? spec_p : round_p;
  assign res_flags  = (state_reg == S_UNPACK) ? spec_flags : round_flags;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) state_reg <= S_IDLE;
    else     state_reg <= state_next;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (bus.in_valid) state_next = S_UNPACK;
      S_UNPACK: state_next = special ? S_DONE : S_MUL;
      S_MUL:    if (cnt_reg == '0) state_next = S_NORM;
      S_NORM:   state_next = S_ROUND;
      S_ROUND:  state_next = S_DONE;
      S_DONE:   if (bus.out_ready) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    bus.in_ready  = (state_reg == S_IDLE);
    bus.out_valid = (state_reg == S_DONE);
  end

  // ---------------- datapath registers ----------------
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      a_reg     <= '0;
      b_reg     <= '0;
      p_reg     <= '0;
      flags_reg <= '0;
      sign_reg  <= 1'b0;
      exp_reg   <= '0;
      cnt_reg   <= '0;
      sig_reg   <= '0;
      g_reg     <= 1'b0;
      r_reg     <= 1'b0;
      s_reg     <= 1'b0;
    end else begin
      if (state_reg == S_IDLE && bus.in_valid) begin
        a_reg     <= bus.a;
        b_reg     <= bus.b;
        flags_reg <= '0;
      end
      if (state_reg == S_UNPACK) begin
        sign_reg <= sa ^ sb;
        exp_reg  <= exp_sum;
        cnt_reg  <= CW'(MUL_LAT - 1);
      end
      if (state_reg == S_MUL && cnt_reg != '0)
        cnt_reg <= cnt_reg - 1'b1;
      if (state_reg == S_NORM) begin
        sig_reg <= prod_n[PW-1 -: MAN_W+1];
        g_reg   <= prod_n[MAN_W];
        r_reg   <= prod_n[MAN_W-1];
        s_reg   <= |prod_n[MAN_W-2:0];
        exp_reg <= exp_reg + EW'(prod_pipe[MUL_LAT-1][PW-1]);
      end
      if (done_entry) begin
        p_reg     <= res_p;
        flags_reg <= res_flags;
      end
    end
  end

  assign bus.p = p_reg;
  assign {bus.of, bus.uf, bus.nan, bus.inf, bus.zf, bus.dnf, bus.nx} = flags_reg;

  // ---------------- sticky status ----------------
`ifdef FP_MUL_STICKY_EN
  logic [6:0] sticky_reg;
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst)
      sticky_reg <= '0;
    else if (done_entry)
      sticky_reg <= (bus.clr_sticky ? 7'b0 : sticky_reg) | res_flags;
    else if (bus.clr_sticky)
      sticky_reg <= '0;
  end
  assign bus.sticky_flags = sticky_reg;
`else
  assign bus.sticky_flags = '0;
`endif

endmodule

// File: tb/tb_fp_mul_seq.sv
// Scoreboard bench for fp_mul_seq (single precision, MUL_LAT=2).
// Driver pushes the hand-computed result per accepted operation; a monitor
// on the falling edge pops and compares whenever out_valid is shown.
module tb_fp_mul_seq;
  logic Clk = 1'b0;
  logic Rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic seen = 1'b0;
  logic [6:0] exp_sticky = '0;

  typedef struct {
    logic [31:0] p;
    logic [6:0]  f;
    int          lat;
    int          acc;
  } exp_t;
  exp_t sb[$];

  fp_mul_seq_if #(.EXP_W(8), .MAN_W(23)) bus ();

  fp_mul_seq #(.EXP_W(8), .MAN_W(23), .MUL_LAT(2)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  function automatic logic [6:0] flags_now();
    return {bus.of, bus.uf, bus.nan, bus.inf, bus.zf, bus.dnf, bus.nx};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every cycle the result is presented (so stalled
  // results are checked for stability too), pops on handshake.
  always @(negedge Clk) begin
    if (!Rst && bus.out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: out_valid=1 with p=%h, no operation outstanding", bus.p);
      end else begin
        if (!seen) begin
          seen = 1'b1;
          chk("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
        end
        chk("p", bus.p, sb[0].p);
        chk("flags", 32'(flags_now()), 32'(sb[0].f));
        if (bus.out_ready) begin
          $display("op done: p=%h flags=%b", bus.p, flags_now());
          void'(sb.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] p, input logic [6:0] f, input int lat);
    exp_t e;
    @(negedge Clk);
    for (int i = 0; i < 40 && !bus.in_ready; i++) @(negedge Clk);
    chk("in_ready_before_issue", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a = a;
    bus.b = b;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    e.p = p; e.f = f; e.lat = lat; e.acc = cyc;
    sb.push_back(e);
`ifdef FP_MUL_STICKY_EN
    exp_sticky |= f;
`endif
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge Clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL timeout: %0d result(s) never delivered", sb.size());
      sb.delete();
      seen = 1'b0;
    end
    @(negedge Clk);
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] p, input logic [6:0] f, input int lat);
    $display("op: a=%h b=%h expect p=%h flags=%b lat=%0d", a, b, p, f, lat);
    issue(a, b, p, f, lat);
    wait_done();
    chk("sticky", 32'(bus.sticky_flags), 32'(exp_sticky));
  endtask

  initial begin
    logic saw_valid;
    bus.in_valid   = 1'b0;
    bus.a          = '0;
    bus.b          = '0;
    bus.out_ready  = 1'b1;
    bus.clr_sticky = 1'b0;
    repeat (3) @(negedge Clk);
    Rst = 1'b0;
    @(negedge Clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_p", bus.p, 32'h0);
    chk("rst_flags", 32'(flags_now()), 32'd0);
    chk("rst_sticky", 32'(bus.sticky_flags), 32'd0);

    // flags order {of,uf,nan,inf,zf,dnf,nx}
    run(32'h3FC00000, 32'h40000000, 32'h40400000, 7'b0000000, 5);  // 1.5*2
    run(32'h3F800800, 32'h3F800800, 32'h3F801000, 7'b0000001, 5);  // tie, LSB 0
    run(32'h3F800800, 32'h3F801800, 32'h3F802002, 7'b0000001, 5);  // tie, LSB 1
    run(32'h7F800000, 32'h00000000, 32'h7FC00000, 7'b0010000, 1);  // inf*0
    run(32'hFF800000, 32'h40000000, 32'hFF800000, 7'b0001000, 1);  // -inf*2
    run(32'h00000001, 32'h3F800000, 32'h00000000, 7'b0000110, 1);  // denormal
    run(32'h7F000000, 32'h40000000, 32'h7F800000, 7'b1001001, 5);  // overflow
    run(32'h3FC00000, 32'h40000000, 32'h40400000, 7'b0000000, 5);  // sticky holds
    run(32'h00800000, 32'h3F000000, 32'h00000000, 7'b0100101, 5);  // underflow
    run(32'hC0000000, 32'h40400000, 32'hC0C00000, 7'b0000000, 5);  // -2*3
    run(32'h3F800001, 32'h3FFFFFFE, 32'h40000000, 7'b0000001, 5);  // round carry
    run(32'h80000000, 32'h3F800000, 32'h80000000, 7'b0000100, 1);  // -0*1
    run(32'h7F800001, 32'h00000000, 32'h7FC00000, 7'b0010000, 1);  // NaN in

    // Clear sticky status
    @(negedge Clk);
    bus.clr_sticky = 1'b1;
    @(negedge Clk);
    bus.clr_sticky = 1'b0;
    exp_sticky = '0;
    chk("sticky_clr", 32'(bus.sticky_flags), 32'd0);

    // Backpressure: result held 4 cycles, second operand offered but ignored
    bus.out_ready = 1'b0;
    $display("op: backpressure a=3FC00000 b=40000000");
    issue(32'h3FC00000, 32'h40000000, 32'h40400000, 7'b0000000, 5);
    for (int i = 0; i < 20 && !bus.out_valid; i++) @(negedge Clk);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.a = 32'h40400000;
      bus.b = 32'h40400000;
      @(negedge Clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_out_valid_held", 32'(bus.out_valid), 32'd1);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    wait_done();
`ifdef FP_MUL_STICKY_EN
    exp_sticky = '0;
`endif
    chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
    repeat (3) @(negedge Clk);
    chk("bp_no_second_op", 32'(bus.out_valid), 32'd0);

    // Reset during MUL: operation abandoned, nothing delivered
    $display("op: reset mid-operation a=3FC00000 b=40000000");
    @(negedge Clk);
    bus.in_valid = 1'b1;
    bus.a = 32'h3FC00000;
    bus.b = 32'h40000000;
    @(posedge Clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge Clk);   // UNPACK
    @(negedge Clk);   // MUL
    Rst = 1'b1;
    @(negedge Clk);
    Rst = 1'b0;
    exp_sticky = '0;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_p", bus.p, 32'h0);
    chk("abort_sticky", 32'(bus.sticky_flags), 32'd0);
    saw_valid = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      saw_valid |= bus.out_valid;
    end
    chk("abort_no_out_valid", 32'(saw_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
